// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector for an 8-bit gray video
// stream. Two on-chip line buffers hold the previous two lines. The output is
// the edge magnitude centred one column and one row behind the input pixel and
// appears exactly 3 clocks after it, together with the delayed qualifiers.
// Optional build macro SOBEL_THRESHOLD_EN: binarise the magnitude against
// THRESHOLD (255 / 0) instead of emitting the saturated magnitude.
module sobel_edge_stream #(
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11,
  parameter int THRESHOLD = 128
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       vid_in_active,
  input  logic       vid_in_hsync,
  input  logic       vid_in_vsync,
  input  logic [7:0] vid_in_gray,
  output logic       vid_out_active,
  output logic       vid_out_hsync,
  output logic       vid_out_vsync,
  output logic [7:0] vid_out_edge
);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAX_WIDTH - 1);

  // Reject configurations the address counter or the comparator cannot cover.
  generate
    if (((1 << ADDR_W) < MAX_WIDTH) || (THRESHOLD < 0) || (THRESHOLD > 2047)) begin : g_bad_params
      $error("sobel_edge_stream: invalid MAX_WIDTH/ADDR_W/THRESHOLD combination");
    end
  endgenerate

  logic [ADDR_W-1:0] col;
  logic [1:0]        row;
  logic              active_d;
  logic              vsync_d;
  logic              active_fall;
  logic              vsync_rise;
  logic              col_sat;
  logic              wr_en;
  logic              rd_en;

  assign active_fall = active_d & ~vid_in_active;
  assign vsync_rise  = vid_in_vsync & ~vsync_d;
  assign col_sat     = (col == COL_LAST);
  // RST is folded into the enables because the RAM block itself is not reset.
  assign rd_en       = vid_in_active & ~RST;
  assign wr_en       = vid_in_active & ~col_sat & ~RST;

  // Line buffers: lb0 holds line y-1, lb1 holds line y-2 (contents never reset).
  logic [7:0]        lb0 [MAX_WIDTH];
  logic [7:0]        lb1 [MAX_WIDTH];
  logic [7:0]        rd0;
  logic [7:0]        rd1;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;

  // Registered reads; lb0's old value is moved to lb1 one cycle later, once the read data exists.
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd0 <= lb0[col];
      rd1 <= lb1[col];
    end
    if (wr_en) lb0[col] <= vid_in_gray;
    wb_en   <= wr_en;
    wb_addr <= col;
    if (wb_en) lb1[wb_addr] <= rd0;
  end

  // Column/row position tracking; vsync clear takes priority over a line end.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col      <= '0;
      row      <= '0;
      active_d <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      active_d <= vid_in_active;
      vsync_d  <= vid_in_vsync;
      if (vid_in_active) begin
        if (!col_sat) col <= col + 1'b1;
      end else if (active_fall) begin
        col <= '0;
      end
      if (vsync_rise) row <= '0;
      else if (active_fall && row != 2'd2) row <= row + 2'd1;
    end
  end

  // Window: left and centre columns are registered; the right column is {rd1, rd0, pix_d}.
  logic [7:0] l_t, l_m, l_b, c_t, c_m, c_b, pix_d;
  logic       act1, hs1, vs1, mask1;

  // S1: shift the window on active pixels and register qualifiers plus border mask.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {l_t, l_m, l_b, c_t, c_m, c_b, pix_d} <= '0;
      {act1, hs1, vs1, mask1}               <= '0;
    end else begin
      if (vid_in_active) begin
        {l_t, l_m, l_b} <= {c_t, c_m, c_b};
        {c_t, c_m, c_b} <= {rd1, rd0, pix_d};
        pix_d           <= vid_in_gray;
      end
      act1  <= vid_in_active;
      hs1   <= vid_in_hsync;
      vs1   <= vid_in_vsync;
      mask1 <= vid_in_active & (row == 2'd2) & (col >= ADDR_W'(2)) & ~col_sat;
    end
  end

  logic [9:0]         sum_l, sum_r, sum_t, sum_b;
  logic signed [10:0] gx_next, gy_next, gx, gy;
  logic               act2, hs2, vs2, mask2;

  // Weighted column/row sums (max 4*255 = 1020) and their signed differences.
  always_comb begin
    sum_l   = {2'b0, l_t} + {1'b0, l_m, 1'b0} + {2'b0, l_b};
    sum_r   = {2'b0, rd1} + {1'b0, rd0, 1'b0} + {2'b0, pix_d};
    sum_t   = {2'b0, l_t} + {1'b0, c_t, 1'b0} + {2'b0, rd1};
    sum_b   = {2'b0, l_b} + {1'b0, c_b, 1'b0} + {2'b0, pix_d};
    gx_next = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    gy_next = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
  end

  // S2: register the gradients alongside the delayed qualifiers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gx <= '0;
      gy <= '0;
      {act2, hs2, vs2, mask2} <= '0;
    end else begin
      gx    <= gx_next;
      gy    <= gy_next;
      act2  <= act1;
      hs2   <= hs1;
      vs2   <= vs1;
      mask2 <= mask1;
    end
  end

  logic [10:0] abs_x, abs_y, mag;
  logic [7:0]  edge_calc;

  // L1 magnitude (max 2040 fits 11 bits), then saturate or binarise.
  always_comb begin
    abs_x = gx[10] ? (~gx + 11'd1) : gx;
    abs_y = gy[10] ? (~gy + 11'd1) : gy;
    mag   = abs_x + abs_y;
`ifdef SOBEL_THRESHOLD_EN
    edge_calc = (mag >= 11'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
    edge_calc = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
  end

  // S3: registered outputs; border pixels and inactive cycles output 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vid_out_active <= 1'b0;
      vid_out_hsync  <= 1'b0;
      vid_out_vsync  <= 1'b0;
      vid_out_edge   <= '0;
    end else begin
      vid_out_active <= act2;
      vid_out_hsync  <= hs2;
      vid_out_vsync  <= vs2;
      vid_out_edge   <= (act2 && mask2) ? edge_calc : 8'h00;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream: stimulus pushes the expected edge of
// every accepted pixel into a queue; a monitor pops and compares whenever the
// DUT presents an active output, and checks the qualifiers against a 3-deep
// delayed copy of the inputs every cycle.
module tb_sobel_edge_stream;

  localparam int MAXW = 2048;
  localparam int TH   = 128;

  logic       CLK;
  logic       RST;
  logic       vid_in_active, vid_in_hsync, vid_in_vsync;
  logic [7:0] vid_in_gray;
  logic       vid_out_active, vid_out_hsync, vid_out_vsync;
  logic [7:0] vid_out_edge;

  sobel_edge_stream #(.MAX_WIDTH(MAXW), .ADDR_W(11), .THRESHOLD(TH)) dut (
    .CLK(CLK), .RST(RST),
    .vid_in_active(vid_in_active), .vid_in_hsync(vid_in_hsync),
    .vid_in_vsync(vid_in_vsync), .vid_in_gray(vid_in_gray),
    .vid_out_active(vid_out_active), .vid_out_hsync(vid_out_hsync),
    .vid_out_vsync(vid_out_vsync), .vid_out_edge(vid_out_edge)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  // Reference model state: pixel history per column (two previous lines) and
  // the 3-pixel columns seen so far on the current line.
  int m0[MAXW];
  int m1[MAXW];
  int ct[MAXW];
  int cm[MAXW];
  int cb[MAXW];
  int row_m = 0;
  int col_m = 0;
  bit pa = 0;
  bit pv = 0;

  function automatic int sobel_ref(int x);
    int gx, gy, mag;
    gx  = (ct[x] + 2*cm[x] + cb[x]) - (ct[x-2] + 2*cm[x-2] + cb[x-2]);
    gy  = (cb[x-2] + 2*cb[x-1] + cb[x]) - (ct[x-2] + 2*ct[x-1] + ct[x]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= TH) ? 255 : 0;
`else
    return (mag > 255) ? 255 : mag;
`endif
  endfunction

  function automatic void model_pixel(int p);
    int x, e;
    x = col_m;
    e = 0;
    if (x < MAXW - 1) begin
      ct[x] = m1[x];
      cm[x] = m0[x];
      cb[x] = p;
      m1[x] = m0[x];
      m0[x] = p;
      if (row_m >= 2 && x >= 2) e = sobel_ref(x);
    end
    exp_q.push_back(e);
    if (col_m < MAXW - 1) col_m++;
  endfunction

  task automatic drive_cycle(input bit a, input bit hs, input bit vs, input int p, input bit r);
    bit vs_rise, fall;
    @(negedge CLK);
    RST           = r;
    vid_in_active = a;
    vid_in_hsync  = hs;
    vid_in_vsync  = vs;
    vid_in_gray   = 8'(p);
    if (r) begin
      exp_q.delete();
      row_m = 0;
      col_m = 0;
      pa    = 0;
      pv    = 0;
    end else begin
      vs_rise = vs && !pv;
      fall    = pa && !a;
      if (a) model_pixel(p);
      if (vs_rise) row_m = 0;
      else if (fall && row_m < 2) row_m++;
      if (fall) col_m = 0;
      pa = a;
      pv = vs;
    end
  endtask

  function automatic int pix_val(int kind, int x, int y);
    case (kind)
      0:       return 8'h80;
      1:       return (x < 10) ? 0 : 255;
      2:       return (2 * x) & 255;
      3:       return (10 * y) & 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // One frame: vsync (starting right as the previous line's active falls),
  // then lines with hsync and random blanking. Optional 2-cycle reset at
  // (rl, rp) and an alternative width for the final line.
  task automatic send_frame(input int kind, input int w0, input int nl,
                            input int rl, input int rp, input int wlast);
    int w;
    repeat (3) drive_cycle(0, 0, 1, 0, 0);
    repeat (2) drive_cycle(0, 0, 0, 0, 0);
    for (int y = 0; y < nl; y++) begin
      w = (y == nl - 1 && wlast > 0) ? wlast : w0;
      repeat (2) drive_cycle(0, 1, 0, 0, 0);
      repeat ($urandom_range(1, 4)) drive_cycle(0, 0, 0, 0, 0);
      for (int x = 0; x < w; x++) begin
        if (y == rl && x == rp) repeat (2) drive_cycle(1, 0, 0, 0, 1);
        drive_cycle(1, 0, 0, pix_val(kind, x, y), 0);
      end
    end
    $display("frame kind=%0d width=%0d lines=%0d last_width=%0d reset_line=%0d", kind, w0, nl, wlast, rl);
  endtask

  // Qualifier delay line of the inputs as seen at each clock; reset empties it.
  logic [2:0] h0 = '0, h1 = '0, h2 = '0;

  // Monitor: compare just after every active edge.
  always @(posedge CLK) begin
    int e;
    if (RST) begin
      h0 = '0; h1 = '0; h2 = '0;
    end else begin
      h2 = h1; h1 = h0;
      h0 = {vid_in_active, vid_in_hsync, vid_in_vsync};
    end
    #1;
    n_vec++;
    if ({vid_out_active, vid_out_hsync, vid_out_vsync} !== h2) begin
      n_err++;
      $display("FAIL sync: got %b expected %b at %0t",
               {vid_out_active, vid_out_hsync, vid_out_vsync}, h2, $time);
    end
    n_vec++;
    if (vid_out_active === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL edge_unexpected: got active output with edge %0d, expected no output at %0t",
                 vid_out_edge, $time);
      end else begin
        e = exp_q.pop_front();
        if (vid_out_edge !== 8'(e)) begin
          n_err++;
          $display("FAIL edge: got %0d expected %0d at %0t", vid_out_edge, e, $time);
        end
      end
    end else if (vid_out_edge !== 8'h00) begin
      n_err++;
      $display("FAIL edge_idle: got %0d expected 0 at %0t", vid_out_edge, $time);
    end
  end

  initial begin
    RST = 1'b1;
    vid_in_active = 1'b0;
    vid_in_hsync  = 1'b0;
    vid_in_vsync  = 1'b0;
    vid_in_gray   = 8'h00;
    for (int i = 0; i < MAXW; i++) begin
      m0[i] = 0; m1[i] = 0; ct[i] = 0; cm[i] = 0; cb[i] = 0;
    end
    repeat (4) drive_cycle(0, 0, 0, 0, 1);
    repeat (3) drive_cycle(0, 0, 0, 0, 0);

    send_frame(0, 1280, 5, -1, 0, 0);      // flat field
    send_frame(1, 40, 4, -1, 0, 0);        // vertical step
    send_frame(2, 64, 4, -1, 0, 0);        // horizontal ramp
    send_frame(3, 64, 4, -1, 0, 0);        // vertical ramp
    send_frame(1, 40, 7, 3, 20, 0);        // step frame, reset mid-line 3
    send_frame(4, 2, 4, -1, 0, 0);         // lines shorter than 3 pixels
    send_frame(4, 1, 3, -1, 0, 0);
    for (int f = 0; f < 4; f++)
      send_frame(4, int'($urandom_range(3, 90)), int'($urandom_range(3, 6)), -1, 0, 0);
    send_frame(4, 2100, 4, -1, 0, 300);    // over-long lines, then a normal one
    send_frame(4, 50, 4, 2, 10, 0);        // random frame with a reset

    repeat (10) drive_cycle(0, 0, 0, 0, 0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outputs still outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Streaming 3x3 Sobel edge detector placed directly downstream of rgb2gray_wrapper.
- Consumes the 8-bit gray video stream with its active/hsync/vsync qualifiers.
- Emits an 8-bit edge-magnitude stream with the same qualifiers, delayed by a fixed pipeline latency.
- Two internal line buffers hold the previous two lines, so the block needs no external memory.

Parameters:
MAX_WIDTH, 2048, maximum active pixels per line held in each line buffer
ADDR_W, 11, column counter / line-buffer address width; must satisfy 2**ADDR_W >= MAX_WIDTH
THRESHOLD, 128, binarisation level; used only when SOBEL_THRESHOLD_EN is defined

Ports:
CLK  in  1  pixel clock, all logic on rising edge
RST  in  1  asynchronous, active-high reset
vid_in_active  in  1  pixel valid, high for the active part of a line
vid_in_hsync  in  1  line sync from the gray stage
vid_in_vsync  in  1  frame sync from the gray stage
vid_in_gray  in  8  gray pixel, unsigned
vid_out_active  out  1  vid_in_active delayed 3 cycles
vid_out_hsync  out  1  vid_in_hsync delayed 3 cycles
vid_out_vsync  out  1  vid_in_vsync delayed 3 cycles
vid_out_edge  out  8  edge magnitude, unsigned

Behaviour:
- Reset: RST high asynchronously clears
  - all outputs to 0;
  - col, row, the 3x3 window, the pipeline and the sync delay lines.
  - Line-buffer RAM contents are not cleared; the border rule below masks them.
- Latency: exactly 3 CLK cycles from input to output, for all qualifiers and data. The window is spatially shifted: the output at input column x, row y is the Sobel result centred on pixel (x-1, y-1).
  - S1: read both line buffers at col (registered read); write the current pixel to line buffer 0 and line buffer 0's old value to line buffer 1; shift the window left by one column.
  - S2: compute Gx and Gy.
  - S3: form the magnitude, saturate, register.
- Col counter (ADDR_W bits):
  - increments on each cycle where vid_in_active=1;
  - clears on the falling edge of vid_in_active;
  - saturates at MAX_WIDTH-1. Pixels beyond that point are not written and produce edge 0.
- Row counter (2 bits, saturating at 2):
  - increments on each falling edge of vid_in_active;
  - clears on the rising edge of vid_in_vsync.
- The window updates only while vid_in_active=1; when it is low, the window and line buffers hold.
- Arithmetic:
  - Gx = (r0+2r1+r2) - (l0+2l1+l2) and Gy = (b0+2b1+b2) - (t0+2t1+t2), each 11-bit signed (range ±1020).
  - mag = |Gx| + |Gy| as 11 bits unsigned; output = min(mag, 255).
- Border: vid_out_edge is forced to 0 whenever the corresponding input pixel has row<2 or col<2. The first two lines of every frame and the first two pixels of every line therefore output 0.
- Output qualifiers: vid_out_edge is 0 whenever the delayed active is 0.
- Simultaneous events:
  - vsync rising in the same cycle as an active falling edge: the vsync clear wins, so row=0.
  - Line shorter than 3 pixels: all of its outputs are 0.
- Reset mid-frame: the block restarts cleanly. The next two lines are masked to 0 regardless of stale RAM contents.

Optional Feature:
SOBEL_THRESHOLD_EN
- Defined: S3 outputs 255 if mag >= THRESHOLD, else 0. The border mask still applies, and latency is unchanged at 3 cycles.
- Undefined: S3 outputs the saturated magnitude as described above; THRESHOLD is ignored.

Test Plan:
- Flat field, every pixel 0x80, 5 lines of 1280 -> vid_out_edge 0 on every active cycle; vid_out_active/hsync/vsync equal the inputs delayed exactly 3 cycles.
- Vertical step, cols 0-9 = 0 and cols 10+ = 255, 4 lines -> rows 2-3 output 255 at input cols 10 and 11 and 0 elsewhere; rows 0-1 are all 0.
- Horizontal ramp, pixel = 2*col, 4 lines of 64 -> output 16 for every col >= 2 on rows >= 2.
- Vertical ramp, pixel = 10*row, 4 lines -> output 80 on rows 2-3 at col >= 2; with SOBEL_THRESHOLD_EN and THRESHOLD=128 -> 0, and with THRESHOLD=64 -> 255.
- RST pulsed for 2 cycles mid-line 3 of a step-pattern frame -> all outputs 0 during and after reset; the next two lines output 0; edges reappear on the third line after reset.
- Line of 2100 active pixels with MAX_WIDTH=2048 -> cols >= 2047 output 0; the following line is processed normally with no address wrap corruption.
